fir_tdm_filter: RTL and testbench

FIR_TDM_FILTER -- requirements
Module: fir_tdm_filter

---
 rtl/fir_tdm_filter.sv | 149 ++++++++++++++
 tb/tb_fir_tdm_filter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tdm_filter.sv
// Time-multiplexed FIR filter: one MAC per cycle. Each channel has its own
// delay line and write pointer, and all channels share one coefficient set.
module fir_tdm_filter #(
  parameter int DATA_W   = 24,
  parameter int COEF_W   = 18,
  parameter int TAPS     = 64,
  parameter int CHANNELS = 2,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int TA_W    = $clog2(TAPS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CH_W-1:0]   i_ch,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_coef_we,
  input  logic [TA_W-1:0]   i_coef_addr,
  input  logic [COEF_W-1:0] i_coef_data,
  output logic              o_coef_err,
  output logic              o_valid,
  output logic [CH_W-1:0]   o_ch,
  output logic [DATA_W-1:0] o_data,
  output logic              o_sat
);

  localparam int ACC_W = DATA_W + COEF_W + TA_W;
  localparam int PRD_W = DATA_W + COEF_W;
  localparam logic signed [COEF_W-1:0] COEF_ONE = {1'b0, {(COEF_W-1){1'b1}}};

  typedef enum logic [1:0] {CLEAR, IDLE, MAC, OUT} state_t;

  state_t                   state_q, state_d;
  logic [TA_W-1:0]          cnt_q;
  logic [CH_W-1:0]          ch_q;
  logic [TA_W-1:0]          wr_ptr [CHANNELS];
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] dl     [CHANNELS][TAPS];
  logic signed [COEF_W-1:0] coef   [TAPS];

  logic                     ch_ok, accept, cnt_last;
  logic [TA_W-1:0]          rd_idx;
  logic signed [DATA_W-1:0] x_rd;
  logic signed [COEF_W-1:0] c_rd;
  logic signed [PRD_W-1:0]  prod;
  logic signed [ACC_W-1:0]  prod_ext;

  // Round half up, drop the Q1.(COEF_W-1) fraction, clamp to DATA_W; MSB = clamped.
  function automatic logic [DATA_W:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] r;
    logic                    fits;
    rnd = '0;
    rnd[COEF_W-2] = 1'b1;
    r = (a + rnd) >>> (COEF_W-1);
    fits = (r[ACC_W-1:DATA_W-1] == '0) || (r[ACC_W-1:DATA_W-1] == '1);
    if (fits)
      round_sat = {1'b0, r[DATA_W-1:0]};
    else if (r[ACC_W-1])
      round_sat = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else
      round_sat = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  generate
    if (CHANNELS == (1 << CH_W)) begin : g_ch_full
      assign ch_ok = 1'b1;
    end else begin : g_ch_part
      assign ch_ok = ({1'b0, i_ch} < (CH_W+1)'(CHANNELS));
    end
  endgenerate

  assign o_ready  = (state_q == IDLE) & i_en & ~i_coef_we;
  assign accept   = i_valid & o_ready;
  assign cnt_last = (cnt_q == '1);

  // MAC datapath: tap k reads the sample k positions behind the write pointer.
  assign rd_idx   = wr_ptr[ch_q] - cnt_q;
  assign x_rd     = dl[ch_q][rd_idx];
  assign c_rd     = coef[cnt_q];
  assign prod     = x_rd * c_rd;
  assign prod_ext = {{TA_W{prod[PRD_W-1]}}, prod};

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (cnt_last) state_d = IDLE;
      IDLE:    if (accept && ch_ok) state_d = MAC;
      MAC:     if (cnt_last) state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      ch_q       <= '0;
      acc_q      <= '0;
      o_valid    <= 1'b0;
      o_coef_err <= 1'b0;
      o_data     <= '0;
      o_ch       <= '0;
      o_sat      <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) wr_ptr[c] <= '0;
    end else if (i_en) begin
      state_q    <= state_d;
      o_valid    <= 1'b0;
      o_coef_err <= i_coef_we & (state_q != IDLE);
      case (state_q)
        CLEAR: cnt_q <= cnt_q + TA_W'(1);
        IDLE: begin
          cnt_q <= '0;
          acc_q <= '0;
          if (accept && ch_ok) ch_q <= i_ch;
        end
        MAC: begin
          acc_q <= acc_q + prod_ext;
          cnt_q <= cnt_q + TA_W'(1);
        end
        OUT: begin
          {o_sat, o_data} <= round_sat(acc_q);
          o_ch            <= ch_q;
          o_valid         <= 1'b1;
          wr_ptr[ch_q]    <= wr_ptr[ch_q] + TA_W'(1);
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Storage has no reset; the CLEAR sweep initialises it after every reset.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (state_q == CLEAR) begin
        for (int c = 0; c < CHANNELS; c++) dl[c][cnt_q] <= '0;
        coef[cnt_q] <= (cnt_q == '0) ? COEF_ONE : '0;
      end else if (state_q == IDLE) begin
        if (i_coef_we)
          coef[i_coef_addr] <= i_coef_data;
        else if (accept && ch_ok)
          dl[i_ch][wr_ptr[i_ch]] <= i_data;
      end
    end
  end

endmodule

// File: tb/tb_fir_tdm_filter.sv
// Scoreboard bench for fir_tdm_filter: directed samples queue their expected
// result and latency, and a negedge monitor checks each o_valid pulse.
module tb_fir_tdm_filter;

  localparam int DATA_W   = 24;
  localparam int COEF_W   = 18;
  localparam int TAPS     = 64;
  localparam int CHANNELS = 2;
  localparam int CH_W     = 1;
  localparam int TA_W     = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              i_valid;
  logic              o_ready;
  logic [CH_W-1:0]   i_ch;
  logic [DATA_W-1:0] i_data;
  logic              i_coef_we;
  logic [TA_W-1:0]   i_coef_addr;
  logic [COEF_W-1:0] i_coef_data;
  logic              o_coef_err;
  logic              o_valid;
  logic [CH_W-1:0]   o_ch;
  logic [DATA_W-1:0] o_data;
  logic              o_sat;

  fir_tdm_filter #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .CHANNELS(CHANNELS)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_valid(i_valid),
    .o_ready(o_ready), .i_ch(i_ch), .i_data(i_data),
    .i_coef_we(i_coef_we), .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
    .o_coef_err(o_coef_err), .o_valid(o_valid), .o_ch(o_ch),
    .o_data(o_data), .o_sat(o_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int data;
    int sat;
    int lat;
    int t0;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   nout   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_valid === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid got data %0d want no output", $signed(o_data));
        end else begin
          e = q.pop_front();
          chk($sformatf("out%0d_data", nout), int'($signed(o_data)), e.data);
          chk($sformatf("out%0d_sat", nout), int'(o_sat), e.sat);
          chk($sformatf("out%0d_ch", nout), int'(o_ch), e.ch);
          chk($sformatf("out%0d_latency", nout), cyc - e.t0, e.lat);
        end
        nout++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (o_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    if (o_ready !== 1'b1) chk("ready_timeout", int'(o_ready), 1);
  endtask

  task automatic send(input int ch, input int d, input bit push,
                      input int ed, input int es, input int extra);
    exp_t e;
    wait_ready();
    i_valid = 1'b1;
    i_ch    = ch[CH_W-1:0];
    i_data  = d[DATA_W-1:0];
    tick();
    i_valid = 1'b0;
    if (push) begin
      e.ch = ch; e.data = ed; e.sat = es; e.lat = TAPS + 1 + extra; e.t0 = cyc;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 3000) begin
      tick();
      n++;
    end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
    tick();
    tick();
  endtask

  task automatic coef_wr(input int addr, input int data);
    wait_ready();
    i_coef_we   = 1'b1;
    i_coef_addr = addr[TA_W-1:0];
    i_coef_data = data[COEF_W-1:0];
    tick();
    i_coef_we   = 1'b0;
  endtask

  task automatic do_reset();
    int n = 0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_ready", int'(o_ready), 0);
    chk("rst_coef_err", int'(o_coef_err), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_ch", int'(o_ch), 0);
    chk("rst_sat", int'(o_sat), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do begin
      tick();
      n++;
    end while (o_ready !== 1'b1 && n < 200);
    chk("clear_len", n, TAPS);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 1'b0; en = 1'b1; i_valid = 1'b0; i_ch = '0; i_data = '0;
    i_coef_we = 1'b0; i_coef_addr = '0; i_coef_data = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // Default coefficients pass the sample through
    send(0, 32768, 1, 32768, 0, 0);
    drain();

    // Interleaved channels
    for (int i = 0; i < 2; i++) begin
      send(0, 1000, 1, 1000, 0, 0);
      send(1, -1000, 1, -1000, 0, 0);
    end
    drain();

    // Coefficient write during MAC is rejected
    send(0, 2000, 1, 2000, 0, 0);
    repeat (10) tick();
    i_coef_we = 1'b1; i_coef_addr = '0; i_coef_data = '0;
    tick();
    chk("coef_err_pulse", int'(o_coef_err), 1);
    i_coef_we = 1'b0;
    tick();
    chk("coef_err_clear", int'(o_coef_err), 0);
    drain();
    send(0, 2000, 1, 2000, 0, 0);
    drain();

    // Enable held low mid-MAC for 10 cycles
    send(0, 3000, 1, 3000, 0, 10);
    repeat (20) tick();
    en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    en = 1'b1;
    drain();

    // Reset mid-MAC: no output, CLEAR re-runs
    send(0, 7777, 0, 0, 0, 0);
    repeat (20) tick();
    do_reset();

    // Impulse through coef[k] = k*100 with wrap back to zero
    for (int k = 0; k < TAPS; k++) coef_wr(k, k * 100);
    send(0, 32768, 1, 0, 0, 0);
    for (int n = 1; n <= TAPS; n++) send(0, 0, 1, (n < TAPS) ? 25 * n : 0, 0, 0);
    drain();

    // Saturation with coef[0..3] near unity
    for (int k = 0; k < TAPS; k++) coef_wr(k, (k < 4) ? 131071 : 0);
    send(0, 8388607, 1, 8388543, 0, 0);
    for (int i = 0; i < 3; i++) send(0, 8388607, 1, 8388607, 1, 0);
    send(0, -8388608, 1, 8388607, 1, 0);
    send(0, -8388608, 1, -2, 0, 0);
    send(0, -8388608, 1, -8388608, 1, 0);
    send(0, -8388608, 1, -8388608, 1, 0);
    drain();

    // Reset restores the default coefficient set
    coef_wr(0, 0);
    do_reset();
    send(1, 5000, 1, 5000, 0, 0);
    drain();

    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
